// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. It inhibits the bus, issues the start condition, and
// shifts one byte, odd parity and stop out on device clock falling edges. It then samples the ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_HOLD     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned TCNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  START_LAST   = CNT_W'(START_HOLD - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [9:0]        frame_q, frame_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]        bitn_q, bitn_d;
  logic              nak_q, nak_d;
  logic [7:0]        filt_q, filt_d;
  logic              f_val_q, f_val_d;
  logic              d_meta_q, d_sync_q;
  logic              c_low_q, c_low_d;
  logic              d_low_q, d_low_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              neg_edge;
  logic              in_wait;

  // Device clock is deglitched: the level only changes after eight identical samples.
  always_comb begin
    filt_d  = {ps2c_in, filt_q[7:1]};
    f_val_d = f_val_q;
    if (filt_q == 8'hFF)      f_val_d = 1'b1;
    else if (filt_q == 8'h00) f_val_d = 1'b0;
    neg_edge = f_val_q & ~f_val_d;
  end

  assign in_wait = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_RELEASE);

  // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    bitn_d  = bitn_q;
    nak_d   = nak_q;
    c_low_d = c_low_q;
    d_low_d = d_low_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A start colliding with the done pulse of the previous transfer is dropped.
        if (tx_start && !done_q) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = '0;
          c_low_d = 1'b1;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          d_low_d = 1'b1;
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == START_LAST) begin
          c_low_d = 1'b0;
          bitn_d  = '0;
          tcnt_d  = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        if (neg_edge) begin
          d_low_d = ~frame_q[0];
          frame_d = {1'b1, frame_q[9:1]};
          if (bitn_q == 4'd9) state_d = S_ACK;
          else                bitn_d  = bitn_q + 1'b1;
        end
      end
      S_ACK: begin
        if (neg_edge) begin
          nak_d   = d_sync_q;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (f_val_q && d_sync_q) begin
          done_d  = 1'b1;
          err_d   = nak_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The watchdog only fires while waiting on the device, and never pre-empts a normal finish.
    if (in_wait) begin
      if (neg_edge) begin
        tcnt_d = '0;
      end else if (state_d == state_q) begin
        if (tcnt_q == TIMEOUT_LAST) begin
          c_low_d = 1'b0;
          d_low_d = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      frame_q  <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      bitn_q   <= '0;
      nak_q    <= 1'b0;
      filt_q   <= 8'hFF;
      f_val_q  <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
      c_low_q  <= 1'b0;
      d_low_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      bitn_q   <= bitn_d;
      nak_q    <= nak_d;
      filt_q   <= filt_d;
      f_val_q  <= f_val_d;
      d_meta_q <= ps2d_in;
      d_sync_q <= d_meta_q;
      c_low_q  <= c_low_d;
      d_low_q  <= d_low_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ps2c_drive_low = c_low_q;
  assign ps2d_drive_low = d_low_q;
  assign tx_busy        = busy_q;
  assign tx_done        = done_q;
  assign tx_err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx. A behavioural keyboard clocks frames out of the host, and expected
// completions are queued at each start and retired by a monitor on every tx_done pulse.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int SH  = 8;
  localparam int TO  = 1500;
  localparam int H   = 25;   // device clock half period in clk cycles
  localparam int NV  = 9;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_err;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;
  logic [9:0] dev_bits = '0;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       err;
    logic       chk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_miss = 0;

  // Hand-computed vectors: data, odd parity bit, device ACKs, clock glitch, tx_start inject, reset.
  logic [7:0] v_data   [NV] = '{8'hED, 8'h00, 8'hFF, 8'h01, 8'h80, 8'hED, 8'hED, 8'hA5, 8'h3C};
  logic       v_par    [NV] = '{1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
  logic       v_ack    [NV] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1};
  logic       v_glitch [NV] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
  int         v_inject [NV] = '{-1, -1, -1, -1, -1, -1, 5, -1, -1};
  int         v_abort  [NV] = '{-1, -1, -1, -1, -1, -1, -1, 4, -1};

  // Open-drain bus: a line is low if either side pulls it.
  assign ps2c_in = ~(ps2c_drive_low | dev_c_low);
  assign ps2d_in = ~(ps2d_drive_low | dev_d_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_HOLD    (SH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tx_data       (tx_data),
    .tx_start      (tx_start),
    .ps2c_in       (ps2c_in),
    .ps2d_in       (ps2d_in),
    .ps2c_drive_low(ps2c_drive_low),
    .ps2d_drive_low(ps2d_drive_low),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tx_err        (tx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every tx_done retires the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && tx_done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: got tx_done=1, expected no outstanding transfer (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("tx_err", {31'd0, tx_err}, {31'd0, mon_e.err});
        check("lines_released_at_done", {29'd0, tx_busy, ps2c_drive_low, ps2d_drive_low}, 32'd0);
        if (mon_e.chk)
          check("frame_bits", {22'd0, dev_bits}, {22'd0, 1'b1, mon_e.par, mon_e.data});
      end
    end
  end

  // Issue a command and measure the inhibit and start-condition phases; ends at ps2c release.
  task automatic start_xfer(input logic [7:0] d, input logic par, input logic err, input logic chk);
    exp_t e;
    int   n;
    @(negedge clk);
    check("idle_before_start", {31'd0, tx_busy}, 32'd0);
    tx_data  = d;
    tx_start = 1'b1;
    e = '{data: d, par: par, err: err, chk: chk};
    exp_q.push_back(e);
    @(negedge clk);
    tx_start = 1'b0;
    check("start_latency", {29'd0, tx_busy, ps2c_drive_low, ps2d_drive_low}, 32'd6);
    n = 0;
    while (ps2c_drive_low && !ps2d_drive_low && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INH);
    n = 0;
    while (ps2c_drive_low && ps2d_drive_low && n < 10000) begin
      n++;
      @(negedge clk);
    end
    check("start_hold", n, SH);
  endtask

  // Keyboard model: 11 clocks, samples data on each rising edge, optionally ACKs on the 11th.
  task automatic dev_xfer(input logic ack, input logic glitch, input int inject_at, input int abort_at);
    exp_t dropped;
    dev_bits = '0;
    repeat (H) @(negedge clk);
    for (int e = 0; e < 11; e++) begin
      if (e == abort_at) begin
        #2 reset_n = 1'b0;
        #1 check("async_reset_release", {29'd0, ps2c_drive_low, ps2d_drive_low, tx_busy}, 32'd0);
        dropped = exp_q.pop_back();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (e == 10 && ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_c_low = 1'b0;
      if (e < 10) dev_bits[e] = ps2d_in;
      dev_d_low = 1'b0;
      if (e == inject_at) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (H - 1) @(negedge clk);
      end else if (glitch && e == 5) begin
        repeat (8) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (4) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (H - 12) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, ps2c_drive_low, ps2d_drive_low, tx_busy, tx_done, tx_err}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      start_xfer(v_data[v], v_par[v], ~v_ack[v], 1'b1);
      dev_xfer(v_ack[v], v_glitch[v], v_inject[v], v_abort[v]);
      n = 0;
      while (tx_busy && n < 2000) begin
        n++;
        @(negedge clk);
      end
      repeat (20) @(negedge clk);
      check("idle_after_xfer", {29'd0, tx_busy, ps2c_drive_low, ps2d_drive_low}, 32'd0);
    end

    // Silent device: the host must give up exactly TO cycles after releasing ps2c.
    start_xfer(8'hF0, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!tx_done && n < TO + 100) begin
      n++;
      @(negedge clk);
    end
    check("timeout_cycles", n, TO);
    repeat (20) @(negedge clk);
    check("idle_after_timeout", {29'd0, tx_busy, ps2c_drive_low, ps2d_drive_low}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
